// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: reset, lock wait with timeout/retry, lock debounce, system reset release.
// Optional lock-loss event counter is built when PLL_LOCK_LOSS_COUNT_EN is defined.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 50000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_d;
  logic [1:0]       sync_q;
  logic             lock_s;

  // Two-flop synchronizer for the asynchronous lock flag
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], pll_locked};
  end
  assign lock_s = sync_q[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET_PLL;
      cnt_q     <= '0;
      retry_cnt <= 4'd0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_cnt <= retry_d;
      // Outputs decoded from next state so they move with the transition edge
      pll_rst   <= (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
      sys_rst   <= (state_d != ST_RUN);
      ready     <= (state_d == ST_RUN);
      fail      <= (state_d == ST_FAIL);
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_cnt;
    case (state_q)
      ST_RESET_PLL: if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_cnt == RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            retry_d = retry_cnt + 4'd1;
            state_d = ST_RESET_PLL;
          end
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = 4'd0;
        end
      end
      ST_RUN:  if (!lock_s) state_d = ST_LOST;
      ST_LOST: state_d = ST_RESET_PLL;
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RESET_PLL;
    endcase
    // Relock overrides everything, including a restart from within RESET_PLL
    if (relock_req) begin
      state_d = ST_RESET_PLL;
      retry_d = 4'd0;
    end
    cnt_d = (relock_req || (state_d != state_q)) ? '0 : cnt_q + CNT_W'(1);
  end

  assign state = state_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
  logic loss_event;
  assign loss_event = (state_q == ST_RUN) && !lock_s;

  // Saturating count of RUN exits caused by lock loss; survives relock_req
  always_ff @(posedge refclk or posedge rst) begin
    if (rst)                                  lock_loss_cnt <= 8'd0;
    else if (loss_event && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: vector table, timed corner sequences,
// and random lock/relock stimulus against a cycle-level reference model.
module tb_pll_lock_sequencer;

  localparam int unsigned RST_C  = 4;
  localparam int unsigned TO_C   = 20;
  localparam int unsigned ST_C   = 8;
  localparam int unsigned MAXR   = 2;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst, sys_rst, ready, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  pll_lock_sequencer #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO_C), .STABLE_CYCLES(ST_C),
    .MAX_RETRIES(MAXR), .CNT_W(16)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .state(state), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [18:0] dut_vec;
  assign dut_vec = {state, pll_rst, sys_rst, ready, fail, retry_cnt, lock_loss_cnt};

  // Reference model: phase number, time spent in phase, retries, loss events, lock history
  int m_state, m_timer, m_retry, m_loss;
  bit m_hist[$];

  function automatic void model_reset();
    m_state = 0; m_timer = 0; m_retry = 0; m_loss = 0;
    m_hist.delete();
    m_hist.push_back(1'b0);
    m_hist.push_back(1'b0);
  endfunction

  function automatic void model_step(bit pl, bit rr);
    bit ls;
    int nxt;
    ls = m_hist.pop_front();
    m_hist.push_back(pl);
    nxt = m_state;
    if (m_state == 0 && m_timer == RST_C - 1) nxt = 1;
    if (m_state == 1) begin
      if (ls) nxt = 2;
      else if (m_timer == TO_C - 1) begin
        if (m_retry == MAXR) nxt = 5;
        else begin m_retry = m_retry + 1; nxt = 0; end
      end
    end
    if (m_state == 2) begin
      if (!ls) nxt = 1;
      else if (m_timer == ST_C - 1) begin nxt = 3; m_retry = 0; end
    end
    if (m_state == 3 && !ls) begin
      nxt = 4;
      if (m_loss < 255) m_loss = m_loss + 1;
    end
    if (m_state == 4) nxt = 0;
    if (rr) begin nxt = 0; m_retry = 0; end
    m_timer = (rr || nxt != m_state) ? 0 : m_timer + 1;
    m_state = nxt;
  endfunction

  function automatic logic [7:0] exp_loss(int n);
`ifdef PLL_LOCK_LOSS_COUNT_EN
    return 8'(n);
`else
    return 8'(0 * n);
`endif
  endfunction

  function automatic logic [18:0] model_vec();
    logic prst, srst, rdy, fl;
    prst = (m_state == 0) || (m_state == 5);
    srst = (m_state != 3);
    rdy  = (m_state == 3);
    fl   = (m_state == 5);
    return {3'(m_state), prst, srst, rdy, fl, 4'(m_retry), exp_loss(m_loss)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    model_step(pll_locked, relock_req);
    #1;
    chk("model", 32'(dut_vec), 32'(model_vec()));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    #2;
    model_reset();
    chk("reset_values", 32'(dut_vec), 32'({3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0}));
    @(posedge refclk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_ready(input int max, input string name);
    int k;
    k = 0;
    while (!ready && k < max) begin tick(); k++; end
    if (!ready) chk(name, 32'(ready), 32'd1);
  endtask

  typedef struct {
    bit pl; bit rr; int n;
    int st; bit prst; bit srst; bit rdy; bit fl; int rt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit pl, bit rr, int n, int st, bit prst, bit srst,
                              bit rdy, bit fl, int rt);
    vec_t v;
    v.pl = pl; v.rr = rr; v.n = n; v.st = st; v.prst = prst;
    v.srst = srst; v.rdy = rdy; v.fl = fl; v.rt = rt;
    return v;
  endfunction

  initial begin
    // Never-lock through FAIL, then relock_req recovery to RUN
    tbl.push_back(mk(0, 0,   3, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,   1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,  19, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0,   1, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,   3, 0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,   1, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,  19, 1, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0,   1, 0, 1, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0,   4, 1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0,  19, 1, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0,   1, 5, 1, 1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 120, 5, 1, 1, 0, 1, 2));
    tbl.push_back(mk(1, 1,   1, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0,   3, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0,   1, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0,   1, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0,   7, 2, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0,   1, 3, 0, 0, 1, 0, 0));

    do_reset();
    foreach (tbl[i]) begin
      pll_locked = tbl[i].pl;
      relock_req = tbl[i].rr;
      run(tbl[i].n);
      relock_req = 1'b0;
      chk($sformatf("vec%0d", i),
          32'({state, pll_rst, sys_rst, ready, fail, retry_cnt}),
          32'({3'(tbl[i].st), tbl[i].prst, tbl[i].srst, tbl[i].rdy, tbl[i].fl, 4'(tbl[i].rt)}));
    end

    // Clean lock: lock driven 5 cycles after pll_rst falls, ready 11 edges later
    do_reset();
    run(9);
    chk("clean_wait", 32'({state, pll_rst}), 32'({3'd1, 1'b0}));
    pll_locked = 1'b1;
    run(10);
    chk("clean_pre_ready", 32'(ready), 32'd0);
    run(1);
    chk("clean_ready", 32'({ready, sys_rst, retry_cnt}), 32'({1'b1, 1'b0, 4'd0}));

    // Lock glitch at STABLE count 5: back to WAIT_LOCK, no pll_rst pulse on re-lock
    do_reset();
    run(9);
    pll_locked = 1'b1;
    run(8);
    chk("glitch_stable", 32'(state), 32'd2);
    pll_locked = 1'b0;
    run(3);
    chk("glitch_back", 32'({state, ready}), 32'({3'd1, 1'b0}));
    pll_locked = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("glitch_relock", 32'({pll_rst, ready}), (k == 11) ? 32'd1 : 32'd0);
    end

    // Lock loss in RUN: LOST at edge 3, pll_rst at edge 4 for 4 cycles
    run(2);
    pll_locked = 1'b0;
    run(2);
    chk("loss_still_run", 32'({state, ready}), 32'({3'd3, 1'b1}));
    run(1);
    chk("loss_lost", 32'({state, sys_rst, ready, pll_rst}), 32'({3'd4, 1'b1, 1'b0, 1'b0}));
    run(1);
    chk("loss_prst", 32'({state, pll_rst}), 32'({3'd0, 1'b1}));
    run(3);
    chk("loss_prst_hold", 32'({state, pll_rst}), 32'({3'd0, 1'b1}));
    run(1);
    chk("loss_wait", 32'({state, pll_rst}), 32'({3'd1, 1'b0}));
    chk("loss_count", 32'(lock_loss_cnt), 32'(exp_loss(1)));
    pll_locked = 1'b1;
    run(11);
    chk("loss_relock", 32'(ready), 32'd1);

    // Saturation: 260 more lock-loss exits, every other one colliding with relock_req
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      relock_req = i[0];
      tick();
      relock_req = 1'b0;
      wait_ready(40, "sat_timeout");
    end
    chk("sat_value", 32'(lock_loss_cnt), 32'(exp_loss(255)));
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("sat_relock_keeps", 32'(lock_loss_cnt), 32'(exp_loss(255)));
    do_reset();
    chk("sat_rst_clears", 32'(lock_loss_cnt), 32'd0);

    // Random lock behaviour with occasional relock requests
    for (int seg = 0; seg < 150; seg++) begin
      int len;
      pll_locked = ($urandom_range(0, 99) < 85);
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        relock_req = ($urandom_range(0, 63) == 0);
        tick();
      end
    end
    relock_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
